// File: rtl/hand_scorer.sv
//==============================================================================
// Module      : hand_scorer
// Description : Accumulates player/dealer card totals over a valid/ready card
//               stream and publishes soft/hard totals plus hand status flags.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hand_scorer #(
    parameter int MAX_CARDS = 11,
    parameter int TOTAL_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_hand,
    input  logic               card_valid,
    input  logic [3:0]         card_rank,
    input  logic               card_dest,
    output logic               card_ready,
    output logic               card_err,
    output logic [TOTAL_W-1:0] p_low,
    output logic [TOTAL_W-1:0] p_high,
    output logic [TOTAL_W-1:0] d_low,
    output logic [TOTAL_W-1:0] d_high,
    output logic [TOTAL_W-1:0] d_up,
    output logic [3:0]         p_cards,
    output logic [3:0]         d_cards,
    output logic               p_bust,
    output logic               d_bust,
    output logic               p_blackjack,
    output logic               d_blackjack
);

    localparam logic [TOTAL_W-1:0] c_SAT = '1;
    localparam logic [TOTAL_W-1:0] c_TEN = TOTAL_W'(10);
    localparam logic [TOTAL_W-1:0] c_BJ  = TOTAL_W'(21);
    localparam logic [3:0]         c_MAX = 4'(MAX_CARDS);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_OPEN  = 1'b1
    } state_t;

    state_t                    state_q;
    logic [1:0][TOTAL_W-1:0]   low_q;
    logic [1:0][3:0]           cards_q;
    logic [1:0]                ace_q;
    logic [TOTAL_W-1:0]        up_q;
    logic                      err_q;

    logic [1:0][TOTAL_W-1:0]   high;
    logic [1:0]                bust;
    logic [1:0]                locked;
    logic [1:0]                bj;
    logic [3:0]                value;
    logic                      legal;
    logic [TOTAL_W-1:0]        low_d;
    logic [TOTAL_W-1:0]        up_d;
    logic                      accept;

    function automatic logic [TOTAL_W-1:0] sat_add(
        input logic [TOTAL_W-1:0] a,
        input logic [TOTAL_W-1:0] b
    );
        logic [TOTAL_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[TOTAL_W] ? c_SAT : s[TOTAL_W-1:0];
    endfunction

    always_comb begin
        legal = (card_rank >= 4'd1) && (card_rank <= 4'd13);
        if (card_rank == 4'd1) begin
            value = 4'd1;
        end else if (card_rank <= 4'd10) begin
            value = card_rank;
        end else begin
            value = 4'd10;
        end
        // The dealer up-card reports an ace at its soft value.
        up_d  = (card_rank == 4'd1) ? TOTAL_W'(11) : TOTAL_W'(value);
        low_d = sat_add(low_q[card_dest], TOTAL_W'(value));
    end

    for (genvar i = 0; i < 2; i++) begin : g_side
        assign high[i]   = ace_q[i] ? sat_add(low_q[i], c_TEN) : low_q[i];
        assign bust[i]   = low_q[i] > c_BJ;
        assign locked[i] = bust[i] || (cards_q[i] == c_MAX);
        assign bj[i]     = (cards_q[i] == 4'd2) && (high[i] == c_BJ);
    end

    assign card_ready = (state_q == S_OPEN) && !new_hand && !locked[card_dest];
    assign accept     = card_valid && card_ready && legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_CLEAR;
            low_q   <= '0;
            cards_q <= '0;
            ace_q   <= '0;
            up_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= card_valid && card_ready && !legal;
            case (state_q)
                S_CLEAR: begin
                    low_q   <= '0;
                    cards_q <= '0;
                    ace_q   <= '0;
                    up_q    <= '0;
                    state_q <= new_hand ? S_CLEAR : S_OPEN;
                end
                S_OPEN: begin
                    if (new_hand) begin
                        // Clear on the pulse edge so the next cycle already shows zeros.
                        low_q   <= '0;
                        cards_q <= '0;
                        ace_q   <= '0;
                        up_q    <= '0;
                        state_q <= S_CLEAR;
                    end else if (accept) begin
                        low_q[card_dest]   <= low_d;
                        cards_q[card_dest] <= cards_q[card_dest] + 4'd1;
                        if (card_rank == 4'd1) begin
                            ace_q[card_dest] <= 1'b1;
                        end
                        if (card_dest && (cards_q[1] == 4'd0)) begin
                            up_q <= up_d;
                        end
                    end
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    assign card_err    = err_q;
    assign p_low       = low_q[0];
    assign d_low       = low_q[1];
    assign p_high      = high[0];
    assign d_high      = high[1];
    assign d_up        = up_q;
    assign p_cards     = cards_q[0];
    assign d_cards     = cards_q[1];
    assign p_bust      = bust[0];
    assign d_bust      = bust[1];
    assign p_blackjack = bj[0];
    assign d_blackjack = bj[1];

endmodule

`default_nettype wire

// File: tb/tb_hand_scorer.sv
//==============================================================================
// Module      : tb_hand_scorer
// Description : Directed self-checking bench for hand_scorer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hand_scorer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       new_hand = 1'b0;
    logic       card_valid = 1'b0;
    logic [3:0] card_rank = 4'd0;
    logic       card_dest = 1'b0;
    logic       card_ready, card_err;
    logic [4:0] p_low, p_high, d_low, d_high, d_up;
    logic [3:0] p_cards, d_cards;
    logic       p_bust, d_bust, p_blackjack, d_blackjack;
    logic [38:0] all_out;

    int errors = 0;
    int checks = 0;

    hand_scorer #(.MAX_CARDS(11), .TOTAL_W(5)) dut (
        .clk(clk), .reset(reset), .new_hand(new_hand), .card_valid(card_valid),
        .card_rank(card_rank), .card_dest(card_dest), .card_ready(card_ready),
        .card_err(card_err), .p_low(p_low), .p_high(p_high), .d_low(d_low),
        .d_high(d_high), .d_up(d_up), .p_cards(p_cards), .d_cards(d_cards),
        .p_bust(p_bust), .d_bust(d_bust), .p_blackjack(p_blackjack),
        .d_blackjack(d_blackjack)
    );

    assign all_out = {card_ready, card_err, p_low, p_high, d_low, d_high, d_up,
                      p_cards, d_cards, p_bust, d_bust, p_blackjack, d_blackjack};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_new_hand();
        @(negedge clk); new_hand = 1'b1;
        @(negedge clk); new_hand = 1'b0;
    endtask

    // Presents one card and holds it until accepted (bounded wait).
    task automatic deal(input logic dest, input logic [3:0] rank);
        int n = 0;
        @(negedge clk);
        card_valid = 1'b1; card_dest = dest; card_rank = rank;
        #1;
        while (!card_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!card_ready) begin
            checks++; errors++;
            $display("FAIL deal_timeout: card_ready=%0b required 1 (dest=%0d rank=%0d)", card_ready, dest, rank);
        end
        @(posedge clk); #1;
        card_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (all_out !== 39'd0) begin
            errors++; $display("FAIL reset_outputs: got %h required 0", all_out);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_blackjack();
        pulse_new_hand();
        deal(1'b0, 4'd1); deal(1'b1, 4'd9); deal(1'b0, 4'd13);
        checks++; if (p_low !== 5'd11) begin errors++; $display("FAIL bj_p_low: got %0d required 11", p_low); end
        checks++; if (p_high !== 5'd21) begin errors++; $display("FAIL bj_p_high: got %0d required 21", p_high); end
        checks++; if (p_cards !== 4'd2) begin errors++; $display("FAIL bj_p_cards: got %0d required 2", p_cards); end
        checks++; if (p_blackjack !== 1'b1) begin errors++; $display("FAIL bj_flag: got %0b required 1", p_blackjack); end
        checks++; if (d_up !== 5'd9) begin errors++; $display("FAIL bj_d_up: got %0d required 9", d_up); end
        checks++;
        if ({d_low, d_high, d_cards, d_blackjack} !== {5'd9, 5'd9, 4'd1, 1'b0}) begin
            errors++; $display("FAIL bj_dealer: got low=%0d high=%0d cards=%0d bj=%0b required 9 9 1 0", d_low, d_high, d_cards, d_blackjack);
        end
    endtask

    task automatic test_soft_aces();
        pulse_new_hand();
        deal(1'b0, 4'd1); deal(1'b0, 4'd1); deal(1'b0, 4'd9);
        checks++;
        if ({p_low, p_high, p_cards, p_blackjack} !== {5'd11, 5'd21, 4'd3, 1'b0}) begin
            errors++; $display("FAIL soft_three: got low=%0d high=%0d cards=%0d bj=%0b required 11 21 3 0", p_low, p_high, p_cards, p_blackjack);
        end
        deal(1'b0, 4'd13);
        checks++;
        if ({p_low, p_high, p_bust} !== {5'd21, 5'd31, 1'b0}) begin
            errors++; $display("FAIL soft_sat: got low=%0d high=%0d bust=%0b required 21 31 0", p_low, p_high, p_bust);
        end
    endtask

    task automatic test_bust_lock();
        pulse_new_hand();
        deal(1'b0, 4'd10); deal(1'b0, 4'd12); deal(1'b0, 4'd5);
        checks++;
        if ({p_low, p_bust} !== {5'd25, 1'b1}) begin
            errors++; $display("FAIL bust_total: got low=%0d bust=%0b required 25 1", p_low, p_bust);
        end
        @(negedge clk); card_valid = 1'b1; card_dest = 1'b0; card_rank = 4'd2; #1;
        checks++; if (card_ready !== 1'b0) begin errors++; $display("FAIL bust_ready: got %0b required 0", card_ready); end
        @(posedge clk); #1;
        checks++;
        if ({p_low, p_cards} !== {5'd25, 4'd3}) begin
            errors++; $display("FAIL bust_hold: got low=%0d cards=%0d required 25 3", p_low, p_cards);
        end
        card_dest = 1'b1; card_rank = 4'd7; #1;
        checks++; if (card_ready !== 1'b1) begin errors++; $display("FAIL bust_other_ready: got %0b required 1", card_ready); end
        @(posedge clk); #1;
        card_valid = 1'b0;
        checks++;
        if ({d_low, d_up, d_cards} !== {5'd7, 5'd7, 4'd1}) begin
            errors++; $display("FAIL bust_dealer: got low=%0d up=%0d cards=%0d required 7 7 1", d_low, d_up, d_cards);
        end
    endtask

    task automatic test_illegal();
        pulse_new_hand();
        deal(1'b0, 4'd5);
        @(negedge clk); card_valid = 1'b1; card_dest = 1'b0; card_rank = 4'd0;
        @(posedge clk); #1;
        checks++;
        if ({card_err, p_low, p_cards} !== {1'b1, 5'd5, 4'd1}) begin
            errors++; $display("FAIL illegal_0: got err=%0b low=%0d cards=%0d required 1 5 1", card_err, p_low, p_cards);
        end
        card_rank = 4'd14;
        @(posedge clk); #1;
        card_valid = 1'b0;
        checks++;
        if ({card_err, p_low, p_cards} !== {1'b1, 5'd5, 4'd1}) begin
            errors++; $display("FAIL illegal_14: got err=%0b low=%0d cards=%0d required 1 5 1", card_err, p_low, p_cards);
        end
        @(posedge clk); #1;
        checks++; if (card_err !== 1'b0) begin errors++; $display("FAIL illegal_pulse: got %0b required 0", card_err); end
    endtask

    task automatic test_new_hand_collision();
        @(negedge clk); new_hand = 1'b1; card_valid = 1'b1; card_dest = 1'b0; card_rank = 4'd5; #1;
        checks++; if (card_ready !== 1'b0) begin errors++; $display("FAIL nh_ready: got %0b required 0", card_ready); end
        @(posedge clk); #1;
        new_hand = 1'b0; card_valid = 1'b0;
        checks++; if (all_out !== 39'd0) begin errors++; $display("FAIL nh_clear: got %h required 0", all_out); end
        @(posedge clk); #1;
        checks++; if (card_ready !== 1'b1) begin errors++; $display("FAIL nh_reopen: got %0b required 1", card_ready); end
    endtask

    task automatic test_max_cards();
        pulse_new_hand();
        for (int i = 0; i < 11; i++) deal(1'b0, 4'd1);
        checks++;
        if ({p_cards, p_low, p_high, p_bust, p_blackjack} !== {4'd11, 5'd11, 5'd21, 1'b0, 1'b0}) begin
            errors++; $display("FAIL max_state: got cards=%0d low=%0d high=%0d bust=%0b bj=%0b required 11 11 21 0 0", p_cards, p_low, p_high, p_bust, p_blackjack);
        end
        @(negedge clk); card_valid = 1'b1; card_dest = 1'b0; card_rank = 4'd3; #1;
        checks++; if (card_ready !== 1'b0) begin errors++; $display("FAIL max_ready: got %0b required 0", card_ready); end
        card_dest = 1'b1; #1;
        checks++; if (card_ready !== 1'b1) begin errors++; $display("FAIL max_other_ready: got %0b required 1", card_ready); end
        card_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        pulse_new_hand();
        deal(1'b0, 4'd7); deal(1'b1, 4'd4);
        @(posedge clk); #3;
        reset = 1'b1; #1;
        checks++; if (all_out !== 39'd0) begin errors++; $display("FAIL async_clear: got %h required 0", all_out); end
        @(negedge clk); reset = 1'b0;
        deal(1'b1, 4'd1);
        checks++;
        if ({d_up, d_low, d_high, d_cards} !== {5'd11, 5'd1, 5'd11, 4'd1}) begin
            errors++; $display("FAIL async_dealer_ace: got up=%0d low=%0d high=%0d cards=%0d required 11 1 11 1", d_up, d_low, d_high, d_cards);
        end
    endtask

    initial begin
        test_reset();
        test_blackjack();
        test_soft_aces();
        test_bust_lock();
        test_illegal();
        test_new_hand_collision();
        test_max_cards();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
